instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS pipeline. Holds the program counter and issues single-cycle-accept requests to instruction memory. Fills the IF/ID pipeline register. Applies PC redirects resolved in decode, where the jump target arrives already sign-extended from the 26-bit instruction field by the SignExtend_26X32 block.

---
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: PC register, single-cycle instruction memory
// requests, IF/ID register and a one-word skid buffer for stalls.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched on a redirect edge.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Data,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Jump,
  input  logic [31:0] Jump_Target_32,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Offset_32,
  output logic [31:0] PC,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_Plus4_ID,
  output logic        Valid_ID
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    STALLED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;

  logic        transfer;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // Upper index bits fall off the word-to-byte shift; targets wrap mod 2^32.
  logic unused_target_hi;
  assign unused_target_hi = ^{Jump_Target_32[31:30], Branch_Offset_32[31:30]};

  // Request and address depend on registered state only.
  assign Imem_Req    = (state_q == FETCH);
  assign Imem_Addr   = pc_q;
  assign PC          = pc_q;
  assign Instr_ID    = instr_q;
  assign PC_Plus4_ID = pc4_q;
  assign Valid_ID    = valid_q;

  assign transfer      = Imem_Req & Imem_Ready;
  assign redirect      = (Jump | Branch_Taken) & valid_q & ~Stall;
  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {Jump_Target_32[29:0], 2'b00};
  assign branch_target = pc4_q + {Branch_Offset_32[29:0], 2'b00};

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    skid_d  = skid_q;

    if (Flush) begin
      // Skid word is dropped; PC never advanced past it, so it is refetched.
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (redirect) begin
      pc_d    = Jump ? jump_target : branch_target;
      state_d = FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
      if (state_q == STALLED) begin
        instr_d = skid_q;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end else if (transfer) begin
        instr_d = Imem_Data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
`else
      valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        RST_WAIT: state_d = FETCH;
        FETCH: begin
          if (Stall) begin
            if (transfer) begin
              skid_d  = Imem_Data;
              state_d = STALLED;
            end
          end else if (transfer) begin
            instr_d = Imem_Data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            valid_d = 1'b0;
          end
        end
        STALLED: begin
          if (!Stall) begin
            instr_d = skid_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end
        default: state_d = RST_WAIT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_WAIT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      // NOTE: skid occupancy is encoded by STALLED; its data is reset only to keep it deterministic.
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized traffic compared against a transaction-level fetch model.
module tb_instruction_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Data;
  logic        Stall, Flush, Jump, Branch_Taken;
  logic [31:0] Jump_Target_32, Branch_Offset_32;
  logic [31:0] PC, Instr_ID, PC_Plus4_ID;
  logic        Valid_ID;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .Imem_Req         (Imem_Req),
    .Imem_Addr        (Imem_Addr),
    .Imem_Ready       (Imem_Ready),
    .Imem_Data        (Imem_Data),
    .Stall            (Stall),
    .Flush            (Flush),
    .Jump             (Jump),
    .Jump_Target_32   (Jump_Target_32),
    .Branch_Taken     (Branch_Taken),
    .Branch_Offset_32 (Branch_Offset_32),
    .PC               (PC),
    .Instr_ID         (Instr_ID),
    .PC_Plus4_ID      (PC_Plus4_ID),
    .Valid_ID         (Valid_ID)
  );

  // Instruction memory content: an odd multiplier keeps every word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign Imem_Data = mem_word(Imem_Addr);

  // Reference model: program counter, decode-stage slot and a queue of fetched-but-parked words.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic        m_wait;
  logic [31:0] m_skid[$];

  function automatic logic model_req();
    return !m_wait && (m_skid.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_wait = 1'b1;
    m_skid.delete();
  endtask

  task automatic model_update();
    logic        xfer;
    logic [31:0] tgt;
    xfer = model_req() && Imem_Ready;
    if (Flush) begin
      m_valid = 1'b0; m_wait = 1'b0; m_skid.delete();
    end else if ((Jump || Branch_Taken) && m_valid && !Stall) begin
      tgt = Jump ? (Jump_Target_32 << 2) : (m_pc4 + (Branch_Offset_32 << 2));
      m_valid = 1'b0;
      if (DS && m_skid.size() != 0) begin
        m_instr = m_skid[0]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end else if (DS && xfer) begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = tgt; m_wait = 1'b0; m_skid.delete();
    end else if (m_wait) begin
      m_wait = 1'b0;
    end else if (Stall) begin
      if (xfer) m_skid.push_back(mem_word(m_pc));
    end else if (m_skid.size() != 0) begin
      m_instr = m_skid.pop_front(); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end else if (xfer) begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [129:0] snap();
    return {PC, Imem_Addr, Imem_Req, Instr_ID, PC_Plus4_ID, Valid_ID};
  endfunction

  function automatic logic [129:0] msnap();
    return {m_pc, m_pc, model_req(), m_instr, m_pc4, m_valid};
  endfunction

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; Flush = 1'b0; Jump = 1'b0; Branch_Taken = 1'b0;
    Jump_Target_32 = 32'h0; Branch_Offset_32 = 32'h0; Imem_Ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({PC, Imem_Req, Instr_ID, PC_Plus4_ID, Valid_ID} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin bad++; $display("FAIL reset_values act=%h", {PC, Imem_Req, Instr_ID, PC_Plus4_ID, Valid_ID}); end
    reset = 1'b0;
    #2;
    total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL reset_wait_req act=%b exp=0", Imem_Req); end
    step();
    total++; if ({Imem_Req, PC, Valid_ID} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL first_fetch act=%b/%h/%b exp=1/0/0", Imem_Req, PC, Valid_ID); end
    step();
    total++; if ({Valid_ID, PC_Plus4_ID, Instr_ID, PC} !== {1'b1, 32'h4, mem_word(32'h0), 32'h4}) begin bad++; $display("FAIL first_ifid act=%b/%h/%h/%h", Valid_ID, PC_Plus4_ID, Instr_ID, PC); end
    step();
    total++; if (Imem_Addr !== 32'h8) begin bad++; $display("FAIL stream_addr act=%h exp=8", Imem_Addr); end
    total++; if (snap() !== msnap()) begin bad++; $display("FAIL reset_model act=%h exp=%h", snap(), msnap()); end
  endtask

  task automatic test_not_ready();
    for (int i = 0; i < 16 && PC !== 32'h10; i++) step();
    total++; if (PC !== 32'h10) begin bad++; $display("FAIL reach_0x10 act=%h exp=10", PC); end
    Imem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({Valid_ID, PC} !== {1'b0, 32'h10}) begin bad++; $display("FAIL bubble%0d act=%b/%h exp=0/10", i, Valid_ID, PC); end
    end
    Imem_Ready = 1'b1;
    step();
    total++; if ({PC, Instr_ID, Valid_ID} !== {32'h14, mem_word(32'h10), 1'b1}) begin bad++; $display("FAIL resume act=%h/%h/%b", PC, Instr_ID, Valid_ID); end
    total++; if (snap() !== msnap()) begin bad++; $display("FAIL not_ready_model act=%h exp=%h", snap(), msnap()); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16 && PC !== 32'h20; i++) step();
    total++; if (PC !== 32'h20) begin bad++; $display("FAIL reach_0x20 act=%h exp=20", PC); end
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if ({Imem_Req, Instr_ID, PC, Valid_ID} !== {1'b0, mem_word(32'h1C), 32'h20, 1'b1}) begin bad++; $display("FAIL stall_hold%0d act=%b/%h/%h/%b", i, Imem_Req, Instr_ID, PC, Valid_ID); end
    end
    Stall = 1'b0;
    step();
    total++; if ({Instr_ID, PC_Plus4_ID, PC, Imem_Req, Valid_ID} !== {mem_word(32'h20), 32'h24, 32'h24, 1'b1, 1'b1}) begin bad++; $display("FAIL stall_release act=%h/%h/%h/%b", Instr_ID, PC_Plus4_ID, PC, Imem_Req); end
    step();
    total++; if ({Instr_ID, PC_Plus4_ID} !== {mem_word(32'h24), 32'h28}) begin bad++; $display("FAIL stall_next act=%h/%h", Instr_ID, PC_Plus4_ID); end
  endtask

  task automatic test_jump();
    Jump = 1'b1; Jump_Target_32 = 32'hFFFF_FFFE;
    step();
    Jump = 1'b0;
    total++; if ({PC, Valid_ID} !== {32'hFFFF_FFF8, DS}) begin bad++; $display("FAIL jump_neg act=%h/%b exp=fffffff8/%b", PC, Valid_ID, DS); end
    step();
    total++; if ({Instr_ID, PC_Plus4_ID, Valid_ID} !== {mem_word(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b1}) begin bad++; $display("FAIL jump_first act=%h/%h/%b", Instr_ID, PC_Plus4_ID, Valid_ID); end
    Jump = 1'b1; Jump_Target_32 = 32'h6;
    step();
    Jump = 1'b0;
    total++; if (PC !== 32'h18) begin bad++; $display("FAIL jump_pos act=%h exp=18", PC); end
    total++; if (snap() !== msnap()) begin bad++; $display("FAIL jump_model act=%h exp=%h", snap(), msnap()); end
  endtask

  task automatic test_branch();
    step();
    Jump = 1'b1; Jump_Target_32 = 32'h40;
    step();
    Jump = 1'b0;
    step();
    total++; if ({PC_Plus4_ID, Valid_ID} !== {32'h104, 1'b1}) begin bad++; $display("FAIL branch_setup act=%h/%b exp=104/1", PC_Plus4_ID, Valid_ID); end
    Branch_Taken = 1'b1; Branch_Offset_32 = 32'hFFFF_FFFE;
    step();
    Branch_Taken = 1'b0;
    total++; if (PC !== 32'hFC) begin bad++; $display("FAIL branch_back act=%h exp=fc", PC); end
    step();
    Jump = 1'b1; Jump_Target_32 = 32'h80; Branch_Taken = 1'b1; Branch_Offset_32 = 32'h4;
    step();
    Jump = 1'b0; Branch_Taken = 1'b0;
    total++; if (PC !== 32'h200) begin bad++; $display("FAIL jump_wins act=%h exp=200", PC); end
    Imem_Ready = 1'b0;
    step();
    total++; if ({Valid_ID, PC} !== {1'b0, 32'h200}) begin bad++; $display("FAIL branch_bubble act=%b/%h", Valid_ID, PC); end
    Imem_Ready = 1'b1; Branch_Taken = 1'b1; Branch_Offset_32 = 32'h10;
    step();
    Branch_Taken = 1'b0;
    total++; if ({PC, Valid_ID} !== {32'h204, 1'b1}) begin bad++; $display("FAIL branch_ignored act=%h/%b exp=204/1", PC, Valid_ID); end
  endtask

  task automatic test_flush();
    Jump = 1'b1; Jump_Target_32 = 32'h10;
    step();
    Jump = 1'b0; Stall = 1'b1;
    step();
    total++; if ({Imem_Req, PC} !== {1'b0, 32'h40}) begin bad++; $display("FAIL flush_stalled act=%b/%h exp=0/40", Imem_Req, PC); end
    Flush = 1'b1;
    step();
    Flush = 1'b0; Stall = 1'b0;
    total++; if ({Valid_ID, Imem_Req, PC} !== {1'b0, 1'b1, 32'h40}) begin bad++; $display("FAIL flush_state act=%b/%b/%h", Valid_ID, Imem_Req, PC); end
    step();
    total++; if ({Instr_ID, PC_Plus4_ID, PC, Valid_ID} !== {mem_word(32'h40), 32'h44, 32'h44, 1'b1}) begin bad++; $display("FAIL flush_refetch act=%h/%h/%h/%b", Instr_ID, PC_Plus4_ID, PC, Valid_ID); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Imem_Ready       = ($urandom_range(0, 9) < 8);
      Stall            = ($urandom_range(0, 9) < 2);
      Flush            = ($urandom_range(0, 19) == 0);
      Jump             = ($urandom_range(0, 11) == 0);
      Branch_Taken     = ($urandom_range(0, 9) == 0);
      Jump_Target_32   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
      Branch_Offset_32 = $urandom_range(0, 1) ? $urandom : (32'h0 - $urandom_range(0, 16));
      step();
      total++; if (snap() !== msnap()) begin bad++; $display("FAIL random_%0d act=%h exp=%h", i, snap(), msnap()); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step();
    #2;
    reset = 1'b1;
    #1;
    total++; if ({PC, Imem_Req, Instr_ID, PC_Plus4_ID, Valid_ID} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin bad++; $display("FAIL reset_async act=%h", {PC, Imem_Req, Instr_ID, PC_Plus4_ID, Valid_ID}); end
    model_reset();
    step();
    reset = 1'b0;
    #1;
    total++; if (Imem_Req !== 1'b0) begin bad++; $display("FAIL reset_mid_wait act=%b exp=0", Imem_Req); end
    step();
    step();
    total++; if ({PC, Instr_ID, Valid_ID} !== {32'h4, mem_word(32'h0), 1'b1}) begin bad++; $display("FAIL reset_mid_resume act=%h/%h/%b", PC, Instr_ID, Valid_ID); end
    total++; if (snap() !== msnap()) begin bad++; $display("FAIL reset_mid_model act=%h exp=%h", snap(), msnap()); end
  endtask

  initial begin
    test_reset();
    test_not_ready();
    test_stall();
    test_jump();
    test_branch();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
